// File: rtl/pkcs7_unstacker_pkg.sv
// Shared types and helpers for the PKCS#7 unstacker.
// Block/word geometry, FSM state and strobe generation.
package pkcs7_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_BYTES  = 4;
  localparam int BLOCK_WORDS = BLOCK_BYTES / WORD_BYTES;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // byte b of word w is live when its block offset is below keep
  function automatic logic [3:0] strb_from_keep(
    input logic [4:0] keep,
    input logic [1:0] w
  );
    logic [3:0] s;
    int         idx;
    s = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      idx  = WORD_BYTES * int'(w) + b;
      s[b] = (idx < int'(keep));
    end
    return s;
  endfunction

  // index of the last word to emit for a given keep count
  function automatic logic [1:0] final_idx(
    input logic [4:0] keep
  );
    logic [4:0] km1;
    km1 = keep - 5'd1;
    return (keep == 5'd0) ? 2'd0 : km1[3:2];
  endfunction

endpackage

// File: rtl/pkcs7_unstacker_if.sv
// Block-in / word-out stream bundle of the unstacker.
// slave = unstacker view, master = producer/consumer view.
interface pkcs7_unstacker_if;

  logic         valid_i;
  logic         ready_o;
  logic [127:0] block_i;
  logic         last_i;
  logic         valid_o;
  logic         ready_i;
  logic [31:0]  word_o;
  logic [3:0]   strb_o;
  logic         last_o;

  modport slave (
    input  valid_i,
    input  block_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output word_o,
    output strb_o,
    output last_o
  );

  modport master (
    output valid_i,
    output block_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  word_o,
    input  strb_o,
    input  last_o
  );

endinterface

// File: rtl/pkcs7_unstacker_pad_checker.sv
// Combinational PKCS#7 trailer check on a 128-bit block.
// keep is the count of payload bytes (16 when padding is malformed).
module pkcs7_pad_checker
  import pkcs7_pkg::*;
(
  input  logic [127:0] block_i,
  output logic         good_o,
  output logic [4:0]   keep_o
);

  logic [7:0] n;
  logic [7:0] byte_k;

  assign n = block_i[127:120];

  always_comb begin
    good_o = (n >= 8'd1) && (n <= 8'd16);
    byte_k = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      byte_k = block_i[8*k +: 8];
      if ((k >= BLOCK_BYTES - int'(n)) && (byte_k != n))
        good_o = 1'b0;
    end
  end

  logic [7:0] keep_full;
  assign keep_full = 8'd16 - n;
  assign keep_o    = good_o ? keep_full[4:0] : 5'd16;

endmodule

// File: rtl/pkcs7_unstacker.sv
// Splits 128-bit plaintext blocks into 32-bit words,
// stripping PKCS#7 padding from the final block.
module pkcs7_unstacker
  import pkcs7_pkg::*;
#(
  parameter bit STRIP_EN = 1'b1,
  parameter bit ERR_PASS = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic enable_i,
  pkcs7_unstacker_if.slave bus,
  output logic pad_err_o
);

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   fin_q, fin_d;
  logic [127:0] block_q, block_d;
  logic         last_q, last_d;
  logic [4:0]   keep_q, keep_d;
  logic         err_q, err_d;

  logic         chk_good;
  logic [4:0]   chk_keep;

  pkcs7_pad_checker u_chk (
    .block_i (bus.block_i),
    .good_o  (chk_good),
    .keep_o  (chk_keep)
  );

  logic live;
  logic emit;
  logic final_w;
  logic acc;
  logic hs;
  logic strip;
  logic bad;
  logic [4:0] keep_new;

  assign live    = rst_ni && !clr_i && enable_i;
  assign emit    = (state_q == EMIT);
  assign final_w = (cnt_q == fin_q);

  assign bus.ready_o = live &&
    (!emit || (final_w && bus.ready_i));
  assign bus.valid_o = live && emit;

  assign acc = bus.valid_i && bus.ready_o;
  assign hs  = bus.valid_o && bus.ready_i;

  assign strip = STRIP_EN && bus.last_i;
  assign bad   = strip && !chk_good;

  // bad trailer: pass whole block or collapse to a terminator
  always_comb begin
    keep_new = 5'd16;
    if (strip) begin
      if (chk_good)      keep_new = chk_keep;
      else if (!ERR_PASS) keep_new = 5'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    block_d = block_q;
    last_d  = last_q;
    keep_d  = keep_q;
    err_d   = err_q;
    if (acc) begin
      state_d = EMIT;
      cnt_d   = 2'd0;
      fin_d   = final_idx(keep_new);
      block_d = bus.block_i;
      last_d  = bus.last_i;
      keep_d  = keep_new;
      err_d   = err_q | bad;
    end else if (hs) begin
      if (final_w) state_d = IDLE;
      else         cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= '0;
      block_q <= '0;
      last_q  <= 1'b0;
      keep_q  <= '0;
      err_q   <= 1'b0;
    end else if (enable_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      block_q <= block_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      err_q   <= err_d;
    end
  end

  assign bus.word_o = (keep_q == 5'd0) ? 32'h0
                    : block_q[{cnt_q, 5'b0} +: 32];
  assign bus.strb_o = strb_from_keep(keep_q, cnt_q);
  assign bus.last_o = emit && last_q && final_w;
  assign pad_err_o  = err_q;

endmodule

// File: tb/tb_pkcs7_unstacker.sv
// Scoreboard bench for pkcs7_unstacker (default parameters).
// Directed blocks; monitor pops expected words on each handshake.
module tb_pkcs7_unstacker;
  import pkcs7_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic en;
  logic pad_err;

  always #5 clk = ~clk;

  pkcs7_unstacker_if bus();

  pkcs7_unstacker dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (clr),
    .enable_i  (en),
    .bus       (bus),
    .pad_err_o (pad_err)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, req);
    end
  endtask

  task automatic expect_w(input logic [31:0] w,
                          input logic [3:0] s,
                          input logic l);
    exp_t e;
    e.w = w; e.s = s; e.l = l;
    exp_q.push_back(e);
  endtask

  // monitor: scoreboard pops and stall-hold checks
  logic        hold_v = 1'b0;
  logic [31:0] hold_w;
  logic [3:0]  hold_s;
  logic        hold_l;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || clr) begin
      hold_v = 1'b0;
    end else if (bus.valid_o) begin
      if (hold_v) begin
        chk("hold_word", bus.word_o, hold_w);
        chk("hold_strb", {28'h0, bus.strb_o}, {28'h0, hold_s});
        chk("hold_last", {31'h0, bus.last_o}, {31'h0, hold_l});
      end
      if (bus.ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("word", bus.word_o, e.w);
          chk("strb", {28'h0, bus.strb_o}, {28'h0, e.s});
          chk("last", {31'h0, bus.last_o}, {31'h0, e.l});
        end
      end
      hold_v = !bus.ready_i;
      hold_w = bus.word_o;
      hold_s = bus.strb_o;
      hold_l = bus.last_o;
    end else if (en && hold_v) begin
      chk("valid_dropped", 32'h0, 32'h1);
      hold_v = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] blk, input logic lst);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.valid_i = 1'b1;
    bus.block_i = blk;
    bus.last_i  = lst;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.ready_o;
      step();
      n++;
    end
    bus.valid_i = 1'b0;
    if (!acc) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 32'h0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    en    = 1'b1;
    bus.valid_i = 1'b0;
    bus.block_i = '0;
    bus.last_i  = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) step();

    @(negedge clk);
    chk("rst_ready", {31'h0, bus.ready_o}, 32'h0);
    chk("rst_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("rst_word", bus.word_o, 32'h0);
    chk("rst_strb", {28'h0, bus.strb_o}, 32'h0);
    chk("rst_last", {31'h0, bus.last_o}, 32'h0);
    chk("rst_err", {31'h0, pad_err}, 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'h0, bus.ready_o}, 32'h1);
    step();

    // 1 + 2 back to back: plain block then 4-byte pad
    expect_w(32'h00000000, 4'hF, 1'b0);
    expect_w(32'h11111111, 4'hF, 1'b0);
    expect_w(32'h22222222, 4'hF, 1'b0);
    expect_w(32'h33333333, 4'hF, 1'b0);
    expect_w(32'h03020100, 4'hF, 1'b0);
    expect_w(32'h07060504, 4'hF, 1'b0);
    expect_w(32'h0B0A0908, 4'hF, 1'b1);
    send(128'h33333333_22222222_11111111_00000000, 1'b0);
    send(128'h04040404_0B0A0908_07060504_03020100, 1'b1);
    drain();

    // 3: N=7, keep=9
    expect_w(32'h33221100, 4'hF, 1'b0);
    expect_w(32'h77665544, 4'hF, 1'b0);
    expect_w(32'h070707AA, 4'b0001, 1'b1);
    send(128'h07070707_070707AA_77665544_33221100, 1'b1);
    drain();

    // 4: full pad block -> terminator
    expect_w(32'h0, 4'h0, 1'b1);
    send({16{8'h10}}, 1'b1);
    chk("err_after_full_pad", {31'h0, pad_err}, 32'h0);
    drain();

    // 5: malformed pad, passed whole
    expect_w(32'h89ABCDEF, 4'hF, 1'b0);
    expect_w(32'h01234567, 4'hF, 1'b0);
    expect_w(32'hDEADBEEF, 4'hF, 1'b0);
    expect_w(32'h03030511, 4'hF, 1'b1);
    send(128'h03030511_DEADBEEF_01234567_89ABCDEF, 1'b1);
    chk("err_set", {31'h0, pad_err}, 32'h1);
    drain();

    // 6a: ready 1,0,0,1 with a 3-cycle freeze inside the stall
    expect_w(32'hA0A0A0A0, 4'hF, 1'b0);
    expect_w(32'hA1A1A1A1, 4'hF, 1'b0);
    expect_w(32'hA2A2A2A2, 4'hF, 1'b0);
    expect_w(32'hA3A3A3A3, 4'hF, 1'b0);
    send(128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 1'b0);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    step();
    step();
    en = 1'b0;
    @(negedge clk);
    chk("frozen_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("frozen_ready", {31'h0, bus.ready_o}, 32'h0);
    repeat (3) step();
    en = 1'b1;
    bus.ready_i = 1'b1;
    drain();
    chk("err_sticky", {31'h0, pad_err}, 32'h1);

    // 6b: clear after first word of a block
    bus.ready_i = 1'b0;
    expect_w(32'hB0B0B0B0, 4'hF, 1'b0);
    send(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 1'b0);
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_ready", {31'h0, bus.ready_o}, 32'h0);
    chk("clr_valid", {31'h0, bus.valid_o}, 32'h0);
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("post_clr_valid", {31'h0, bus.valid_o}, 32'h0);
    chk("post_clr_err", {31'h0, pad_err}, 32'h0);
    chk("post_clr_ready", {31'h0, bus.ready_o}, 32'h1);
    chk("post_clr_queue", exp_q.size(), 32'h0);
    step();
    bus.ready_i = 1'b1;
    expect_w(32'hC0C0C0C0, 4'hF, 1'b0);
    expect_w(32'hC1C1C1C1, 4'hF, 1'b0);
    expect_w(32'hC2C2C2C2, 4'hF, 1'b0);
    expect_w(32'hC3C3C3C3, 4'hF, 1'b0);
    send(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, 1'b0);
    drain();
    @(negedge clk);
    chk("end_idle_valid", {31'h0, bus.valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
